dp_demod: RTL and testbench

DP_DEMOD -- requirements
Module: dp_demod

---
 rtl/dp_demod_if.sv | 29 ++
 rtl/dp_demod.sv | 182 ++++++++++++++++++
 tb/tb_dp_demod.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dp_demod_if.sv
// rtl/dp_demod_if.sv - sample stream bundle between a sample source and dp_demod
// Purpose: groups the demodulator's input sample/phase-step handshake and its
//          output baseband handshake so they travel as one port.
// Signals: ic_val_data  sample strobe (source -> demod)
//          id_data      W-bit signed modulated sample (source -> demod)
//          id_frec_por  M-bit carrier phase increment (source -> demod)
//          od_data      W-bit signed baseband sample (demod -> sink)
//          oc_val_data  od_data strobe (demod -> sink)
// Modports: master = sample source / sink side, slave = demodulator side.
interface dp_demod_if #(
  parameter int W = 16,
  parameter int M = 24
);
  logic                ic_val_data;
  logic signed [W-1:0] id_data;
  logic [M-1:0]        id_frec_por;
  logic signed [W-1:0] od_data;
  logic                oc_val_data;

  modport master (
    output ic_val_data, id_data, id_frec_por,
    input  od_data, oc_val_data
  );

  modport slave (
    input  ic_val_data, id_data, id_frec_por,
    output od_data, oc_val_data
  );
endinterface

// File: rtl/dp_demod.sv
// rtl/dp_demod.sv - AM demodulator: NCO cosine mixer followed by a 2^K moving average
// Purpose: multiplies each valid sample by a cosine carrier from a phase
//          accumulator, low-pass filters the product with a 2^K-tap boxcar and
//          outputs 2*mean, saturated to W bits. Three valid-tagged stages
//          (S1 data+LUT, S2 product, S3 average) give a latency of 3 cycles.
// Ports:   clk     rising-edge clock
//          ic_rst  synchronous active-high reset
//          bus     dp_demod_if.slave (ic_val_data, id_data, id_frec_por in;
//                  od_data, oc_val_data out)
// Option:  define DP_DEMOD_DC_BLOCK_EN to append DC-blocking stage S4
//          y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> 8); latency becomes 4.
// Note:    the cosine table is held at 256-point resolution; L up to 8 maps
//          onto it exactly.
module dp_demod #(
  parameter int W = 16,
  parameter int M = 24,
  parameter int L = 8,
  parameter int K = 4
) (
  input logic       clk,
  input logic       ic_rst,
  dp_demod_if.slave bus
);
  localparam int SW = W + 1 + K;

  // round(32767*cos(2*pi*k/256)) for k = 0..64; the rest follows by symmetry.
  function automatic logic signed [15:0] quarter_cos(input logic [6:0] k);
    case (k)
      7'd0:  quarter_cos = 16'sd32767; 7'd1:  quarter_cos = 16'sd32757; 7'd2:  quarter_cos = 16'sd32728; 7'd3:  quarter_cos = 16'sd32678;
      7'd4:  quarter_cos = 16'sd32609; 7'd5:  quarter_cos = 16'sd32521; 7'd6:  quarter_cos = 16'sd32412; 7'd7:  quarter_cos = 16'sd32285;
      7'd8:  quarter_cos = 16'sd32137; 7'd9:  quarter_cos = 16'sd31971; 7'd10: quarter_cos = 16'sd31785; 7'd11: quarter_cos = 16'sd31580;
      7'd12: quarter_cos = 16'sd31356; 7'd13: quarter_cos = 16'sd31113; 7'd14: quarter_cos = 16'sd30852; 7'd15: quarter_cos = 16'sd30571;
      7'd16: quarter_cos = 16'sd30273; 7'd17: quarter_cos = 16'sd29956; 7'd18: quarter_cos = 16'sd29621; 7'd19: quarter_cos = 16'sd29268;
      7'd20: quarter_cos = 16'sd28898; 7'd21: quarter_cos = 16'sd28510; 7'd22: quarter_cos = 16'sd28105; 7'd23: quarter_cos = 16'sd27683;
      7'd24: quarter_cos = 16'sd27245; 7'd25: quarter_cos = 16'sd26790; 7'd26: quarter_cos = 16'sd26319; 7'd27: quarter_cos = 16'sd25832;
      7'd28: quarter_cos = 16'sd25329; 7'd29: quarter_cos = 16'sd24811; 7'd30: quarter_cos = 16'sd24279; 7'd31: quarter_cos = 16'sd23731;
      7'd32: quarter_cos = 16'sd23170; 7'd33: quarter_cos = 16'sd22594; 7'd34: quarter_cos = 16'sd22005; 7'd35: quarter_cos = 16'sd21403;
      7'd36: quarter_cos = 16'sd20787; 7'd37: quarter_cos = 16'sd20159; 7'd38: quarter_cos = 16'sd19519; 7'd39: quarter_cos = 16'sd18868;
      7'd40: quarter_cos = 16'sd18204; 7'd41: quarter_cos = 16'sd17530; 7'd42: quarter_cos = 16'sd16846; 7'd43: quarter_cos = 16'sd16151;
      7'd44: quarter_cos = 16'sd15446; 7'd45: quarter_cos = 16'sd14732; 7'd46: quarter_cos = 16'sd14010; 7'd47: quarter_cos = 16'sd13279;
      7'd48: quarter_cos = 16'sd12539; 7'd49: quarter_cos = 16'sd11793; 7'd50: quarter_cos = 16'sd11039; 7'd51: quarter_cos = 16'sd10278;
      7'd52: quarter_cos = 16'sd9512;  7'd53: quarter_cos = 16'sd8739;  7'd54: quarter_cos = 16'sd7962;  7'd55: quarter_cos = 16'sd7179;
      7'd56: quarter_cos = 16'sd6393;  7'd57: quarter_cos = 16'sd5602;  7'd58: quarter_cos = 16'sd4808;  7'd59: quarter_cos = 16'sd4011;
      7'd60: quarter_cos = 16'sd3212;  7'd61: quarter_cos = 16'sd2410;  7'd62: quarter_cos = 16'sd1608;  7'd63: quarter_cos = 16'sd804;
      default: quarter_cos = 16'sd0;
    endcase
  endfunction

  // Full 256-point cosine from the quarter wave: quadrants 1 and 2 are negative,
  // quadrants 1 and 3 run the quarter table backwards.
  function automatic logic signed [15:0] cos_lut(input logic [7:0] a);
    logic [6:0] o;
    o = {1'b0, a[5:0]};
    case (a[7:6])
      2'd0:    cos_lut = quarter_cos(o);
      2'd1:    cos_lut = -quarter_cos(7'd64 - o);
      2'd2:    cos_lut = -quarter_cos(o);
      default: cos_lut = quarter_cos(7'd64 - o);
    endcase
  endfunction

  logic [M-1:0] phase;
  logic [L-1:0] lut_addr;
  logic [7:0]   lut_idx;

  assign lut_addr = phase[M-1:M-L];
  generate
    if (L >= 8) begin : g_idx_top
      assign lut_idx = lut_addr[L-1:L-8];
    end else begin : g_idx_pad
      assign lut_idx = {lut_addr, {(8-L){1'b0}}};
    end
  endgenerate

  // S1: capture sample and carrier; the sample sees the phase before its own step.
  logic                s1_val;
  logic signed [W-1:0] s1_data;
  logic signed [15:0]  s1_cos;

  always_ff @(posedge clk) begin
    if (ic_rst) begin
      phase  <= '0;
      s1_val <= 1'b0;
    end else begin
      s1_val <= bus.ic_val_data;
      if (bus.ic_val_data) begin
        phase   <= phase + bus.id_frec_por;
        s1_data <= bus.id_data;
        s1_cos  <= cos_lut(lut_idx);
      end
    end
  end

  // S2: full-precision product, arithmetic shift by 15 into W+1 bits.
  logic                s2_val;
  logic signed [W:0]   s2_prod;

  always_ff @(posedge clk) begin
    if (ic_rst) begin
      s2_val <= 1'b0;
    end else begin
      s2_val <= s1_val;
      if (s1_val) begin
        s2_prod <= (W+1)'(((W+16)'(s1_data) * (W+16)'(s1_cos)) >>> 15);
      end
    end
  end

  // S3: boxcar via running sum; the slot being overwritten holds the oldest sample.
  logic                s3_val;
  logic signed [W-1:0] s3_data;
  logic signed [W:0]   buff [2**K];
  logic [K-1:0]        ptr;
  logic signed [SW-1:0] sum, sum_next;
  logic signed [W+1:0] avg2;
  logic signed [W-1:0] avg_sat;

  assign sum_next = sum + SW'(s2_prod) - SW'(buff[ptr]);
  // 2*(sum >>> K): the kept slice is exactly the shifted value in W+1 bits.
  assign avg2     = {sum_next[SW-1:K], 1'b0};

  always_comb begin
    avg_sat = avg2[W-1:0];
    if (avg2[W+1:W-1] != '0 && avg2[W+1:W-1] != '1) begin
      avg_sat = avg2[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (ic_rst) begin
      sum     <= '0;
      ptr     <= '0;
      s3_val  <= 1'b0;
      s3_data <= '0;
      for (int i = 0; i < 2**K; i++) buff[i] <= '0;
    end else begin
      s3_val <= s2_val;
      if (s2_val) begin
        sum       <= sum_next;
        buff[ptr] <= s2_prod;
        ptr       <= ptr + 1'b1;
        s3_data   <= avg_sat;
      end
    end
  end

`ifdef DP_DEMOD_DC_BLOCK_EN
  // S4: first-order DC blocker with pole at 1 - 2^-8.
  logic                dcb_val;
  logic signed [W-1:0] dcb_x1, dcb_y1, dcb_sat;
  logic signed [W+2:0] dcb_full;

  assign dcb_full = (W+3)'(s3_data) - (W+3)'(dcb_x1) + (W+3)'(dcb_y1) - (W+3)'(dcb_y1 >>> 8);

  always_comb begin
    dcb_sat = dcb_full[W-1:0];
    if (dcb_full[W+2:W-1] != '0 && dcb_full[W+2:W-1] != '1) begin
      dcb_sat = dcb_full[W+2] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (ic_rst) begin
      dcb_val <= 1'b0;
      dcb_x1  <= '0;
      dcb_y1  <= '0;
    end else begin
      dcb_val <= s3_val;
      if (s3_val) begin
        dcb_x1 <= s3_data;
        dcb_y1 <= dcb_sat;
      end
    end
  end

  assign bus.od_data     = dcb_y1;
  assign bus.oc_val_data = dcb_val;
`else
  assign bus.od_data     = s3_data;
  assign bus.oc_val_data = s3_val;
`endif
endmodule

// File: tb/tb_dp_demod.sv
// tb/tb_dp_demod.sv - directed self-checking bench for dp_demod (default build)
// Purpose: drives hand-computed vectors through dp_demod_if and checks
//          reset, latency, averaging ramp, saturation, bubbles/phase and
//          mid-stream reset behaviour.
// Ports:   none (top-level bench).
module tb_dp_demod;
  localparam int W = 16;
  localparam int M = 24;
  localparam int L = 8;
  localparam int K = 4;

  logic clk    = 1'b0;
  logic ic_rst = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  dp_demod_if #(.W(W), .M(M)) bus_if ();

  dp_demod #(.W(W), .M(M), .L(L), .K(K)) dut (
    .clk    (clk),
    .ic_rst (ic_rst),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  // Drive one cycle of input, then sample 1 ns after the capturing edge.
  task automatic step(input logic v, input logic signed [W-1:0] d, input logic [M-1:0] f);
    bus_if.ic_val_data = v;
    bus_if.id_data     = d;
    bus_if.id_frec_por = f;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    ic_rst = 1'b1;
    step(1'b0, '0, '0);
    ic_rst = 1'b0;
  endtask

  task automatic test_reset();
    ic_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'sd12345, 24'h123456);
      vectors++;
      if (bus_if.oc_val_data !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_val[%0d]: got %b expected 0", i, bus_if.oc_val_data);
      end
      vectors++;
      if (bus_if.od_data !== 16'sd0) begin
        miscompares++;
        $display("FAIL reset_data[%0d]: got %0d expected 0", i, bus_if.od_data);
      end
    end
    ic_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0);
      vectors++;
      if (bus_if.oc_val_data !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_val[%0d]: got %b expected 0", i, bus_if.oc_val_data);
      end
      vectors++;
      if (bus_if.od_data !== 16'sd0) begin
        miscompares++;
        $display("FAIL post_reset_data[%0d]: got %0d expected 0", i, bus_if.od_data);
      end
    end
  endtask

  task automatic test_latency();
    logic exp_v;
    logic signed [W-1:0] exp_d;
    apply_reset();
    for (int c = 1; c <= 5; c++) begin
      step(c == 1, 16'sd16384, '0);
      exp_v = (c == 3);
      exp_d = (c >= 3) ? 16'sd2046 : 16'sd0;
      vectors++;
      if (bus_if.oc_val_data !== exp_v) begin
        miscompares++;
        $display("FAIL latency_val[c%0d]: got %b expected %b", c, bus_if.oc_val_data, exp_v);
      end
      vectors++;
      if (bus_if.od_data !== exp_d) begin
        miscompares++;
        $display("FAIL latency_data[c%0d]: got %0d expected %0d", c, bus_if.od_data, exp_d);
      end
    end
  endtask

  // n-th output of a constant 16384 input is 2*floor(16383n/16) = 2048n-2 up to n=16.
  task automatic test_dc_fill();
    logic exp_v;
    logic signed [W-1:0] exp_d;
    apply_reset();
    exp_d = '0;
    for (int c = 1; c <= 23; c++) begin
      step(c <= 20, 16'sd16384, '0);
      exp_v = (c >= 3) && (c <= 22);
      if (exp_v) exp_d = (c - 2 >= 16) ? 16'sd32766 : W'(2048 * (c - 2) - 2);
      vectors++;
      if (bus_if.oc_val_data !== exp_v) begin
        miscompares++;
        $display("FAIL dc_fill_val[c%0d]: got %b expected %b", c, bus_if.oc_val_data, exp_v);
      end
      vectors++;
      if (bus_if.od_data !== exp_d) begin
        miscompares++;
        $display("FAIL dc_fill_data[c%0d]: got %0d expected %0d", c, bus_if.od_data, exp_d);
      end
    end
  endtask

  // Each product is -32767; sum after n samples is -32767n.
  task automatic test_saturation();
    logic exp_v;
    apply_reset();
    for (int c = 1; c <= 19; c++) begin
      step(c <= 16, -16'sd32768, '0);
      exp_v = (c >= 3) && (c <= 18);
      vectors++;
      if (bus_if.oc_val_data !== exp_v) begin
        miscompares++;
        $display("FAIL sat_val[c%0d]: got %b expected %b", c, bus_if.oc_val_data, exp_v);
      end
      if (c == 9) begin
        vectors++;
        if (bus_if.od_data !== -16'sd28672) begin
          miscompares++;
          $display("FAIL sat_n7: got %0d expected -28672", bus_if.od_data);
        end
      end
      if (c == 18 || c == 19) begin
        vectors++;
        if (bus_if.od_data !== -16'sd32768) begin
          miscompares++;
          $display("FAIL sat_clamp[c%0d]: got %0d expected -32768", c, bus_if.od_data);
        end
      end
    end
  endtask

  // Valid samples hit LUT addresses 0,64,128,192: products 16383,0,-16384,0.
  task automatic test_bubbles();
    logic signed [W-1:0] exp_tab [4];
    logic exp_v;
    logic signed [W-1:0] exp_d;
    int n;
    exp_tab = '{16'sd2046, 16'sd2046, -16'sd2, -16'sd2};
    n = 0;
    exp_d = '0;
    apply_reset();
    for (int c = 1; c <= 11; c++) begin
      step((c <= 8) && (c % 2 == 1), 16'sd16384, 24'h400000);
      exp_v = (c - 2 >= 1) && (c - 2 <= 8) && ((c - 2) % 2 == 1);
      if (exp_v) begin
        exp_d = exp_tab[n];
        n++;
      end
      vectors++;
      if (bus_if.oc_val_data !== exp_v) begin
        miscompares++;
        $display("FAIL bubble_val[c%0d]: got %b expected %b", c, bus_if.oc_val_data, exp_v);
      end
      vectors++;
      if (bus_if.od_data !== exp_d) begin
        miscompares++;
        $display("FAIL bubble_data[c%0d]: got %0d expected %0d", c, bus_if.od_data, exp_d);
      end
    end
  endtask

  // Two samples in flight when reset hits at c3; the c4 sample restarts at phase 0.
  task automatic test_midstream_reset();
    logic signed [W-1:0] din [4];
    logic exp_v;
    logic signed [W-1:0] exp_d;
    din = '{16'sd20000, -16'sd15000, 16'sd9999, 16'sd16384};
    apply_reset();
    for (int c = 1; c <= 7; c++) begin
      ic_rst = (c == 3);
      step(c <= 4, (c <= 4) ? din[c-1] : 16'sd0, 24'h400000);
      exp_v = (c == 6);
      exp_d = (c >= 6) ? 16'sd2046 : 16'sd0;
      vectors++;
      if (bus_if.oc_val_data !== exp_v) begin
        miscompares++;
        $display("FAIL midrst_val[c%0d]: got %b expected %b", c, bus_if.oc_val_data, exp_v);
      end
      vectors++;
      if (bus_if.od_data !== exp_d) begin
        miscompares++;
        $display("FAIL midrst_data[c%0d]: got %0d expected %0d", c, bus_if.od_data, exp_d);
      end
    end
    ic_rst = 1'b0;
  endtask

  initial begin
    bus_if.ic_val_data = 1'b0;
    bus_if.id_data     = '0;
    bus_if.id_frec_por = '0;
    test_reset();
    test_latency();
    test_dc_fill();
    test_saturation();
    test_bubbles();
    test_midstream_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
